// File: rtl/taint_mon_pkg.sv
// Shared types for the taint_sum monitor: FSM state encoding, the record
// layout pushed into the record FIFO, and the total-width derivation.
package taint_mon_pkg;

  // Default configuration, used for the reference record layout.
  localparam int DEF_N_SRC = 8;
  localparam int DEF_SUM_W = 8;
  localparam int DEF_CYC_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  // Width of an unsigned sum of n_src values of sum_w bits, no overflow.
  function automatic int tot_w(input int n_src, input int sum_w);
    return sum_w + $clog2(n_src);
  endfunction

  localparam int DEF_TOT_W = tot_w(DEF_N_SRC, DEF_SUM_W);

  // Record layout, most significant field first: {stamp, total, mask}.
  // The monitor packs FIFO words in this same field order for any parameters.
  typedef struct packed {
    logic [DEF_CYC_W-1:0] cycle;
    logic [DEF_TOT_W-1:0] total;
    logic [DEF_N_SRC-1:0] mask;
  } rec_t;

endpackage

// File: rtl/taint_rec_fifo.sv
// Record FIFO. A push into a full FIFO is still accepted when a pop retires
// an entry on the same edge. Synchronous clear beats push and pop.
module taint_rec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             pos_clk,
  input  logic             pos_arst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge pos_clk or posedge pos_arst) begin
    if (pos_arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset because empty gates every reader.
  always_ff @(posedge pos_clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/taint_sum_monitor.sv
// Observes N_SRC taint_sum sources, keeps first-taint / peak / count
// statistics and emits a {stamp, total, mask} record on every change of the
// summed taint. All statistics derive from the registered sample stage.
//
// Record handshake: a record is offered while rec_valid=1 and is retired on
// the rising edge where rec_valid & rec_ready; rec_cycle/rec_total/rec_mask
// hold steady while rec_valid=1 and rec_ready=0, and records leave in order.
module taint_sum_monitor
  import taint_mon_pkg::*;
#(
  parameter  int N_SRC      = 8,
  parameter  int SUM_W      = 8,
  parameter  int CYC_W      = 32,
  parameter  int FIFO_DEPTH = 4,
  localparam int TOT_W      = tot_w(N_SRC, SUM_W)
) (
  input  logic                   pos_clk,
  input  logic                   pos_arst,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [N_SRC*SUM_W-1:0] taint_sum_vec,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [CYC_W-1:0]       rec_cycle,
  output logic [TOT_W-1:0]       rec_total,
  output logic [N_SRC-1:0]       rec_mask,
  output logic                   first_seen,
  output logic [CYC_W-1:0]       first_cycle,
  output logic [TOT_W-1:0]       peak_total,
  output logic [CYC_W-1:0]       tainted_cycles,
  output logic [15:0]            drop_cnt,
  output logic                   overflow,
  output logic [1:0]             dbg_state
);

  localparam int REC_W = CYC_W + TOT_W + N_SRC;

  state_t                 state;
  logic [CYC_W-1:0]       cyc_cnt;
  logic                   s_valid;
  logic [N_SRC*SUM_W-1:0] s_vec;
  logic [CYC_W-1:0]       s_stamp;
  logic [TOT_W-1:0]       total;
  logic [N_SRC-1:0]       mask;
  logic [TOT_W-1:0]       prev_total;
  logic                   taint_hit;
  logic                   push_req;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [REC_W-1:0]       rd_word;

  assign dbg_state = state;
  assign taint_hit = s_valid && (total != '0);
  assign push_req  = s_valid && (total != prev_total);

  // Cycle stamp counter: advances only while sampling.
  always_ff @(posedge pos_clk or posedge pos_arst) begin
    if (pos_arst)            cyc_cnt <= '0;
    else if (clear)          cyc_cnt <= '0;
    else if (enable)         cyc_cnt <= cyc_cnt + CYC_W'(1);
  end

  // Sample stage: capture the sources with their stamp; clear discards the sample.
  always_ff @(posedge pos_clk or posedge pos_arst) begin
    if (pos_arst) begin
      s_valid <= 1'b0;
      s_vec   <= '0;
      s_stamp <= '0;
    end else begin
      s_valid <= enable && !clear;
      if (enable && !clear) begin
        s_vec   <= taint_sum_vec;
        s_stamp <= cyc_cnt;
      end
    end
  end

  // Full-width sum and per-source nonzero mask of the registered sample.
  always_comb begin
    total = '0;
    mask  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      total   = total + TOT_W'(s_vec[i*SUM_W +: SUM_W]);
      mask[i] = |s_vec[i*SUM_W +: SUM_W];
    end
  end

  // Tracking FSM with the first-taint registers it owns.
  always_ff @(posedge pos_clk or posedge pos_arst) begin
    if (pos_arst) begin
      state       <= ST_IDLE;
      first_seen  <= 1'b0;
      first_cycle <= '0;
    end else if (clear) begin
      state       <= enable ? ST_ARMED : ST_IDLE;
      first_seen  <= 1'b0;
      first_cycle <= '0;
    end else begin
      if (state == ST_ARMED && taint_hit) begin
        first_seen  <= 1'b1;
        first_cycle <= s_stamp;
      end
      if (!enable) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE:  state <= first_seen ? ST_TRACK : ST_ARMED;
          ST_ARMED: if (taint_hit) state <= ST_TRACK;
          ST_TRACK: state <= ST_TRACK;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

  // Sample statistics: tainted-cycle count, peak and last recorded total.
  always_ff @(posedge pos_clk or posedge pos_arst) begin
    if (pos_arst) begin
      tainted_cycles <= '0;
      peak_total     <= '0;
      prev_total     <= '0;
    end else if (clear) begin
      tainted_cycles <= '0;
      peak_total     <= '0;
      prev_total     <= '0;
    end else if (s_valid) begin
      if (taint_hit && tainted_cycles != '1) tainted_cycles <= tainted_cycles + CYC_W'(1);
      if (total > peak_total) peak_total <= total;
      prev_total <= total;
    end
  end

  // Drop accounting: a record is lost only when the FIFO is full and not popping.
  always_ff @(posedge pos_clk or posedge pos_arst) begin
    if (pos_arst) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !rec_ready) begin
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      overflow <= 1'b1;
    end
  end

  taint_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .pos_clk  (pos_clk),
    .pos_arst (pos_arst),
    .clear    (clear),
    .push     (push_req),
    .wdata    ({s_stamp, total, mask}),
    .full     (fifo_full),
    .pop      (rec_ready),
    .rdata    (rd_word),
    .empty    (fifo_empty)
  );

  assign rec_valid = !fifo_empty;
  assign {rec_cycle, rec_total, rec_mask} = fifo_empty ? '0 : rd_word;

endmodule

// File: tb/tb_taint_sum_monitor.sv
// Bench for taint_sum_monitor at default parameters: a per-cycle vector table
// for the main record/statistics path, then hand-written sequences for
// enable freeze, clear, FIFO overflow, push-while-full-and-popping and reset.
module tb_taint_sum_monitor;
  import taint_mon_pkg::*;

  localparam int N_SRC = 8;
  localparam int SUM_W = 8;
  localparam int CYC_W = 32;
  localparam int TOT_W = 11;
  localparam int REC_W = $bits(rec_t);

  // ---------------- clock / reset ----------------
  logic                   pos_clk = 1'b0;
  logic                   pos_arst;
  logic                   enable;
  logic                   clear;
  logic [N_SRC*SUM_W-1:0] taint_sum_vec;
  logic                   rec_valid;
  logic                   rec_ready;
  logic [CYC_W-1:0]       rec_cycle;
  logic [TOT_W-1:0]       rec_total;
  logic [N_SRC-1:0]       rec_mask;
  logic                   first_seen;
  logic [CYC_W-1:0]       first_cycle;
  logic [TOT_W-1:0]       peak_total;
  logic [CYC_W-1:0]       tainted_cycles;
  logic [15:0]            drop_cnt;
  logic                   overflow;
  logic [1:0]             dbg_state;

  always #5 pos_clk = ~pos_clk;

  taint_sum_monitor dut (
    .pos_clk        (pos_clk),
    .pos_arst       (pos_arst),
    .enable         (enable),
    .clear          (clear),
    .taint_sum_vec  (taint_sum_vec),
    .rec_valid      (rec_valid),
    .rec_ready      (rec_ready),
    .rec_cycle      (rec_cycle),
    .rec_total      (rec_total),
    .rec_mask       (rec_mask),
    .first_seen     (first_seen),
    .first_cycle    (first_cycle),
    .peak_total     (peak_total),
    .tainted_cycles (tainted_cycles),
    .drop_cnt       (drop_cnt),
    .overflow       (overflow),
    .dbg_state      (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  int model_cyc = 0;
  logic [REC_W-1:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: inputs were driven at the preceding negedge, outputs settle by the next.
  task automatic step();
    @(posedge pos_clk);
    if (clear) model_cyc = 0;
    else if (enable) model_cyc++;
    @(negedge pos_clk);
  endtask

  task automatic push_exp(input int cyc, input int tot, input logic [7:0] m);
    rec_t r;
    r.cycle = CYC_W'(cyc);
    r.total = TOT_W'(tot);
    r.mask  = m;
    exp_q.push_back(r);
  endtask

  // Pops every queued expectation, one record per clock with rec_ready=1.
  task automatic drain(input string tag);
    int k = 0;
    while (exp_q.size() > 0 && k < 16) begin
      logic [REC_W-1:0] e;
      e = exp_q.pop_front();
      check($sformatf("%s_valid%0d", tag, k), 64'(rec_valid), 64'd1);
      check($sformatf("%s_rec%0d", tag, k), 64'({rec_cycle, rec_total, rec_mask}), 64'(e));
      rec_ready = 1'b1;
      step();
      k++;
    end
    check({tag, "_empty"}, 64'(rec_valid), 64'd0);
  endtask

  task automatic check_zero_stats(input string tag);
    check({tag, "_first_seen"}, 64'(first_seen), 64'd0);
    check({tag, "_first_cycle"}, 64'(first_cycle), 64'd0);
    check({tag, "_peak"}, 64'(peak_total), 64'd0);
    check({tag, "_tainted"}, 64'(tainted_cycles), 64'd0);
    check({tag, "_drop"}, 64'(drop_cnt), 64'd0);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
    check({tag, "_rec_valid"}, 64'(rec_valid), 64'd0);
    check({tag, "_rec_word"}, 64'({rec_cycle, rec_total, rec_mask}), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        en;
    logic [63:0] vec;
    logic        v;
    int          tot;
    logic [7:0]  m;
    int          cyc;
    logic        seen;
    int          first;
    int          peak;
    int          taint;
    logic [1:0]  st;
  } row_t;

  row_t tbl[16];

  function automatic row_t mk(input logic en, input logic [63:0] vec, input logic v,
                              input int tot, input logic [7:0] m, input int cyc,
                              input logic seen, input int first, input int peak,
                              input int taint, input logic [1:0] st);
    row_t r;
    r.en = en; r.vec = vec; r.v = v; r.tot = tot; r.m = m; r.cyc = cyc;
    r.seen = seen; r.first = first; r.peak = peak; r.taint = taint; r.st = st;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //           en  vec                      v  tot   mask   cyc seen f  peak  tc st
    tbl[0]  = mk(1, 64'h0,                    0, 0,    8'h00, 0,  0,  0, 0,    0, 2'd1);
    tbl[1]  = mk(1, 64'h0,                    0, 0,    8'h00, 0,  0,  0, 0,    0, 2'd1);
    tbl[2]  = mk(1, 64'h0,                    0, 0,    8'h00, 0,  0,  0, 0,    0, 2'd1);
    tbl[3]  = mk(1, 64'h0,                    0, 0,    8'h00, 0,  0,  0, 0,    0, 2'd1);
    tbl[4]  = mk(1, 64'h0,                    0, 0,    8'h00, 0,  0,  0, 0,    0, 2'd1);
    tbl[5]  = mk(1, 64'h0000_0000_0400_0000,  0, 0,    8'h00, 0,  0,  0, 0,    0, 2'd1);
    tbl[6]  = mk(1, 64'h0,                    1, 4,    8'h08, 5,  1,  5, 4,    1, 2'd2);
    tbl[7]  = mk(1, 64'h0,                    1, 0,    8'h00, 6,  1,  5, 4,    1, 2'd2);
    tbl[8]  = mk(1, 64'hFFFF_FFFF_FFFF_FFFF,  0, 0,    8'h00, 0,  1,  5, 4,    1, 2'd2);
    tbl[9]  = mk(1, 64'h0,                    1, 2040, 8'hFF, 8,  1,  5, 2040, 2, 2'd2);
    tbl[10] = mk(1, 64'h0,                    1, 0,    8'h00, 9,  1,  5, 2040, 2, 2'd2);
    tbl[11] = mk(1, 64'h0200_0000_0000_0001,  0, 0,    8'h00, 0,  1,  5, 2040, 2, 2'd2);
    tbl[12] = mk(1, 64'h0000_0000_0000_0001,  1, 3,    8'h81, 11, 1,  5, 2040, 3, 2'd2);
    tbl[13] = mk(1, 64'h0000_0000_0000_0001,  1, 1,    8'h01, 12, 1,  5, 2040, 4, 2'd2);
    tbl[14] = mk(1, 64'h0,                    0, 0,    8'h00, 0,  1,  5, 2040, 5, 2'd2);
    tbl[15] = mk(0, 64'h0,                    1, 0,    8'h00, 14, 1,  5, 2040, 5, 2'd0);

    // Reset state
    pos_arst = 1'b1; enable = 1'b0; clear = 1'b0; rec_ready = 1'b1; taint_sum_vec = '0;
    repeat (3) @(negedge pos_clk);
    pos_arst = 1'b0;
    model_cyc = 0;
    check_zero_stats("reset");
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));

    // Table: first taint, full-scale sum, mixed masks, repeated totals, enable drop
    for (int i = 0; i < 16; i++) begin
      enable = tbl[i].en;
      taint_sum_vec = tbl[i].vec;
      step();
      check($sformatf("row%0d_valid", i), 64'(rec_valid), 64'(tbl[i].v));
      check($sformatf("row%0d_total", i), 64'(rec_total), 64'(tbl[i].tot));
      check($sformatf("row%0d_mask", i), 64'(rec_mask), 64'(tbl[i].m));
      check($sformatf("row%0d_cycle", i), 64'(rec_cycle), 64'(tbl[i].cyc));
      check($sformatf("row%0d_seen", i), 64'(first_seen), 64'(tbl[i].seen));
      check($sformatf("row%0d_first", i), 64'(first_cycle), 64'(tbl[i].first));
      check($sformatf("row%0d_peak", i), 64'(peak_total), 64'(tbl[i].peak));
      check($sformatf("row%0d_tainted", i), 64'(tainted_cycles), 64'(tbl[i].taint));
      check($sformatf("row%0d_state", i), 64'(dbg_state), 64'(tbl[i].st));
    end

    // Enable low 10 cycles, then resume: stamp counter frozen at 15
    repeat (10) step();
    check("freeze_valid", 64'(rec_valid), 64'd0);
    check("freeze_state", 64'(dbg_state), 64'(ST_IDLE));
    check("freeze_tainted", 64'(tainted_cycles), 64'd5);
    enable = 1'b1;
    taint_sum_vec = 64'h0000_0000_0000_0500;
    step();
    check("resume_state", 64'(dbg_state), 64'(ST_TRACK));
    check("resume_first", 64'(first_cycle), 64'd5);
    taint_sum_vec = '0;
    step();
    check("resume_rec", 64'({rec_cycle, rec_total, rec_mask}), {13'd0, 32'd15, 11'd5, 8'h02});
    check("resume_tainted", 64'(tainted_cycles), 64'd6);

    // Clear while a push (16,0,0) and a pop are pending
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_zero_stats("clear");
    check("clear_state", 64'(dbg_state), 64'(ST_ARMED));
    step();
    check("clear_still_empty", 64'(rec_valid), 64'd0);

    // Overflow: 6 distinct totals into a depth-4 FIFO with no pops
    rec_ready = 1'b0;
    model_cyc = 0;
    // one idle step above advanced the stamp once
    model_cyc = 1;
    for (int k = 1; k <= 6; k++) begin
      taint_sum_vec = 64'(k);
      if (k <= 4) push_exp(model_cyc, k, 8'h01);
      step();
    end
    step();
    step();
    check("ovf_drop", 64'(drop_cnt), 64'd2);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_first", 64'(first_cycle), 64'd1);
    check("ovf_peak", 64'(peak_total), 64'd6);
    step();
    check("ovf_hold_total", 64'(rec_total), 64'd1);
    check("ovf_hold_cycle", 64'(rec_cycle), 64'd1);
    drain("ovf");

    // Full FIFO with a pop and a push on the same edge: nothing dropped
    rec_ready = 1'b0;
    for (int k = 7; k <= 11; k++) begin
      taint_sum_vec = 64'(k) << 16;
      if (k >= 8) push_exp(model_cyc, k, 8'h04);
      step();
    end
    rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
    step();
    check("fullpop_drop", 64'(drop_cnt), 64'd2);
    check("fullpop_total", 64'(rec_total), 64'd8);
    drain("fullpop");

    // Reset mid-handshake with a record offered and not accepted
    rec_ready = 1'b0;
    taint_sum_vec = 64'h0000_0000_0000_000C;
    step();
    step();
    check("prerst_valid", 64'(rec_valid), 64'd1);
    #2 pos_arst = 1'b1;
    #1;
    check_zero_stats("arst");
    check("arst_state", 64'(dbg_state), 64'(ST_IDLE));
    taint_sum_vec = '0;
    @(negedge pos_clk);
    pos_arst = 1'b0;
    model_cyc = 0;
    repeat (3) step();
    check_zero_stats("postrst");
    taint_sum_vec = 64'h0000_0000_0000_0C00;
    step();
    taint_sum_vec = '0;
    step();
    check("postrst_rec", 64'({rec_cycle, rec_total, rec_mask}), {13'd0, 32'd3, 11'd12, 8'h02});
    check("postrst_first", 64'(first_cycle), 64'd3);
    check("postrst_state", 64'(dbg_state), 64'(ST_TRACK));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/taint_sum_monitor.md
TAINT_SUM_MONITOR -- requirements
Module: taint_sum_monitor

Interface
REQ-001 SHALL have parameter N_SRC, default 8, number of taint_sum sources observed.
REQ-002 SHALL have parameter SUM_W, default 8, width of each source taint_sum.
REQ-003 SHALL have parameter CYC_W, default 32, cycle-stamp and counter width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, power of two ≥2, record buffer depth.
REQ-005 SHALL derive TOT_W = SUM_W + clog2(N_SRC); all totals are unsigned TOT_W bits.
REQ-006 pos_clk  in  1  clock, rising edge active.
REQ-007 pos_arst  in  1  reset, asynchronous, active-high.
REQ-008 enable  in  1  sampling enable; clear  in  1  synchronous statistics/FIFO clear.
REQ-009 taint_sum_vec  in  N_SRC*SUM_W  source i at bits [i*SUM_W +: SUM_W].
REQ-010 rec_valid  out  1; rec_ready  in  1; rec_cycle  out  CYC_W; rec_total  out  TOT_W; rec_mask  out  N_SRC (bit i = source i nonzero).
REQ-011 first_seen  out  1; first_cycle  out  CYC_W; peak_total  out  TOT_W; tainted_cycles  out  CYC_W; drop_cnt  out  16; overflow  out  1.

Function
REQ-012 SHALL hold cyc_cnt, incrementing by 1 (wrapping at 2^CYC_W) every cycle enable=1 and clear=0.
REQ-013 SHALL register taint_sum_vec with its cyc_cnt stamp at every edge where enable=1; registered stage is the only source for all statistics.
REQ-014 SHALL compute total = sum of registered sources, full TOT_W width, no saturation, and mask = per-source nonzero.
REQ-015 SHALL run FSM IDLE/ARMED/TRACK: IDLE→ARMED on enable if !first_seen, IDLE→TRACK on enable if first_seen; ARMED→TRACK when sampled total≠0; any state→IDLE when enable=0.
REQ-016 On ARMED→TRACK SHALL set first_seen=1 and latch first_cycle = stamp of that sample; later taint SHALL not alter first_cycle.
REQ-017 SHALL increment tainted_cycles (saturating at all-ones) for each valid sample with total≠0, and set peak_total = max(peak_total, total).
REQ-018 SHALL push record {stamp, total, mask} when a valid sample's total ≠ prev_total, then update prev_total; includes nonzero→zero transitions.
REQ-019 Latency: input change in cycle N SHALL appear at rec_valid in cycle N+2 with empty FIFO.
REQ-020 Handshake: record retired on edge with rec_valid & rec_ready; rec_* SHALL hold stable while rec_valid=1 & rec_ready=0; FIFO order preserved.
REQ-021 Full FIFO with rec_ready=1 in the same cycle SHALL accept the push (simultaneous pop and push).
REQ-022 Full FIFO without pop SHALL drop the record, increment drop_cnt (saturating at 16'hFFFF), set overflow sticky.
REQ-023 clear=1 SHALL at the next edge zero cyc_cnt, prev_total, all statistics, FIFO contents/pointers, drop_cnt, overflow, first_seen; next state ARMED if enable else IDLE; clear overrides simultaneous push, pop and sample.
REQ-024 With enable=0, statistics, FIFO contents and cyc_cnt SHALL hold; draining via rec_ready SHALL continue.

Reset
REQ-025 pos_arst SHALL immediately force state IDLE, rec_valid=0, FIFO empty, all counters, first_seen, first_cycle, peak_total, prev_total, drop_cnt, overflow to 0.
REQ-026 Reset mid-transfer SHALL discard pending records; no record emitted until a post-reset sample qualifies.

Structure
REQ-027 Shared package taint_mon_pkg SHALL hold the state enum, record struct type, and TOT_W derivation function.
REQ-028 FIFO SHALL be sub-module taint_rec_fifo (params WIDTH, DEPTH; push/full, pop/empty, sync clear, pos_arst).

Verification
REQ-029 N_SRC=8,SUM_W=8: enable, all zero 5 cycles, source 3=4 at stamp 5 -> first_cycle=5, record {5,4,8'h08} valid 2 cycles later, state TRACK.
REQ-030 Sources 0..7 all 8'hFF one cycle -> rec_total=11'd2040, peak_total=2040, mask 8'hFF; next sample zero -> record total 0.
REQ-031 rec_ready=0, 6 distinct totals, depth 4 -> 4 records, drop_cnt=2, overflow=1; then rec_ready=1 -> 4 records in order.
REQ-032 FIFO full, rec_ready=1 plus new change same cycle -> no drop, drop_cnt unchanged, occupancy stays 4.
REQ-033 enable low 10 cycles mid-TRACK -> cyc_cnt frozen, re-enable -> TRACK, first_cycle unchanged; clear with pending push -> empty FIFO, all stats 0, state ARMED.
REQ-034 pos_arst asserted mid-handshake with rec_valid=1 -> rec_valid=0 immediately, all outputs 0 until next qualifying sample.
